jof32_hazard_ctrl: RTL

//  Pipeline sequencer for the JOF32 5-stage core. Drives the enable and flush inputs of PC, IF/ID,
//  ID/EX, EX/MEM and MEM/WB. Freezes the pipe on a slow data-memory access (req/ack) and bubbles

---
 rtl/jof32_pipe_pkg.sv | 16 +
 rtl/jof32_fwd_unit.sv | 23 ++
 rtl/jof32_hazard_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/jof32_pipe_pkg.sv
// Shared encodings for the JOF32 pipeline sequencer: FSM states, bypass select codes
// and the default register-address width.
package jof32_pipe_pkg;

   localparam int DEF_REG_ADDR_W = 4;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_FLUSH    = 2'd2;
   localparam logic [1:0] ST_ERROR    = 2'd3;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/jof32_fwd_unit.sv
// EX operand bypass select for one source register; the younger MEM result wins over WB.
module jof32_fwd_unit
   import jof32_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] mem_dir_wb,
   input  logic                  mem_reg_wr,
   input  logic [REG_ADDR_W-1:0] wb_dir_wb,
   input  logic                  wb_reg_wr,
   output logic [1:0]            fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (mem_reg_wr && (mem_dir_wb == ex_rs))
         fwd = FWD_MEM;
      else if (wb_reg_wr && (wb_dir_wb == ex_rs))
         fwd = FWD_WB;
   end

endmodule

// File: rtl/jof32_hazard_ctrl.sv
// JOF32 pipeline sequencer: stage enables/flushes for memory stalls, taken branches and
// load-use bubbles, plus EX operand bypass selection.
module jof32_hazard_ctrl
   import jof32_pipe_pkg::*;
#(
   parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic [REG_ADDR_W-1:0] ex_dir_wb,
   input  logic                  ex_reg_wr,
   input  logic                  ex_mem_rd,
   input  logic [REG_ADDR_W-1:0] mem_dir_wb,
   input  logic                  mem_reg_wr,
   input  logic [REG_ADDR_W-1:0] wb_dir_wb,
   input  logic                  wb_reg_wr,
   input  logic                  branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ack,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  mem_timeout,
   output logic [1:0]            state_o
);

   logic [1:0] state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       err_q, err_n;
   logic [8:0] cnt_inc;
   logic       load_use, run_cycle;
   logic [4:0] en_d;       // {pc, if_id, id_ex, ex_mem, mem_wb}
   logic [1:0] flush_d;    // {if_id, id_ex}
   logic [1:0] fwd_a_raw, fwd_b_raw;

   assign cnt_inc  = {1'b0, cnt} + 9'd1;
   assign load_use = ex_mem_rd && ex_reg_wr &&
                     ((id_use_rs1 && (id_rs1 == ex_dir_wb)) ||
                      (id_use_rs2 && (id_rs2 == ex_dir_wb)));

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      err_n     = err_q;
      en_d      = 5'b00000;
      flush_d   = 2'b00;
      run_cycle = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_req && !mem_ack) begin
               state_n = ST_MEM_WAIT;
               cnt_n   = 8'd1;
            end else begin
               run_cycle = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               run_cycle = 1'b1;
               cnt_n     = 8'd0;
            end else begin
               cnt_n = cnt_inc[7:0];
               if (cnt_inc >= 9'(MEM_TIMEOUT)) begin
                  state_n = ST_ERROR;
                  err_n   = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            en_d    = 5'b11111;
            flush_d = 2'b11;
            if (cnt <= 8'd1) begin
               state_n = ST_RUN;
               cnt_n   = 8'd0;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         default: begin
            err_n = 1'b1;
         end
      endcase

      // A completed access (or no access) is decoded with ordinary branch/load-use rules.
      if (run_cycle) begin
         state_n = ST_RUN;
         if (branch_taken) begin
            en_d    = 5'b11111;
            flush_d = 2'b11;
            if (FLUSH_CYCLES > 1) begin
               state_n = ST_FLUSH;
               cnt_n   = 8'(FLUSH_CYCLES - 1);
            end
         end else if (load_use) begin
            en_d    = 5'b00111;
            flush_d = 2'b01;
         end else begin
            en_d = 5'b11111;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= 8'd0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         err_q <= err_n;
      end
   end

   jof32_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .ex_rs      (ex_rs1),
      .mem_dir_wb (mem_dir_wb),
      .mem_reg_wr (mem_reg_wr),
      .wb_dir_wb  (wb_dir_wb),
      .wb_reg_wr  (wb_reg_wr),
      .fwd        (fwd_a_raw)
   );

   jof32_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .ex_rs      (ex_rs2),
      .mem_dir_wb (mem_dir_wb),
      .mem_reg_wr (mem_reg_wr),
      .wb_dir_wb  (wb_dir_wb),
      .wb_reg_wr  (wb_reg_wr),
      .fwd        (fwd_b_raw)
   );

   // Reset forces a frozen, fully flushed pipe regardless of the decode.
   assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = rst ? 5'b00000 : en_d;
   assign {if_id_flush, id_ex_flush} = rst ? 2'b11 : flush_d;
   assign fwd_a       = rst ? FWD_RF : fwd_a_raw;
   assign fwd_b       = rst ? FWD_RF : fwd_b_raw;
   assign mem_timeout = err_q;
   assign state_o     = state;

endmodule
